wb_ram_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter in front of the SoC main RAM (wb_bfm_memory0); it shares the single RAM slave port between the CPU instruction bus, CPU data bus and debug-unit bus.
- Grant is held for a whole bus cycle (m_cyc high), so classic and burst (CTI/BTE) transfers are atomic.
- A watchdog ends any access that the RAM never acknowledges, terminating it with an error.
- Sits in orpsoc_top between the masters and the memory; the debug bus is driven from the JTAG TAP.

---
 rtl/wb_ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one RAM slave port.
// Grant is held for a full bus cycle; a watchdog errors out stuck accesses.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [LW-1:0]          r_gidx;
  logic [LW-1:0]          w_gidx_nxt;
  logic [LW-1:0]          r_last;
  logic [LW-1:0]          w_last_nxt;
  logic [CW-1:0]          r_wd_cnt;
  logic [CW-1:0]          w_wd_cnt_nxt;

  logic                   w_busy;
  logic                   w_gcyc;
  logic                   w_gstb;
  logic                   w_wd_fire;
  logic                   w_wd_err;
  logic                   w_pick_vld;
  logic [LW-1:0]          w_pick;
  int                     w_best;

  assign w_busy = (r_state == BUSY);

  // Smallest rotated distance from (last+1) wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_best     = NUM_MASTERS;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (m_cyc_i[j] &&
          ((j - int'(r_last) - 1 + 2 * NUM_MASTERS) % NUM_MASTERS) < w_best) begin
        w_best     = (j - int'(r_last) - 1 + 2 * NUM_MASTERS) % NUM_MASTERS;
        w_pick     = LW'(j);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    w_gcyc  = 1'b0;
    w_gstb  = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (r_gidx == LW'(j)) begin
        s_adr_o = m_adr_i[j*AW +: AW];
        s_dat_o = m_dat_i[j*DW +: DW];
        s_sel_o = m_sel_i[j*SW +: SW];
        s_we_o  = m_we_i[j];
        s_cti_o = m_cti_i[j*3 +: 3];
        s_bte_o = m_bte_i[j*2 +: 2];
        w_gcyc  = m_cyc_i[j];
        w_gstb  = m_stb_i[j];
      end
    end
  end

  // Strobe is masked in the firing cycle so the RAM sees no extra access.
  assign w_wd_fire = (TIMEOUT != 0) && w_busy && (r_wd_cnt == TO);
  assign w_wd_err  = w_wd_fire & ~s_ack_i;

  assign s_cyc_o = w_busy & w_gcyc;
  assign s_stb_o = w_busy & w_gstb & ~w_wd_fire;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_wd_err}};
  assign grant_o = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt         = BUSY;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_gidx_nxt          = w_pick;
        end
      end
      BUSY: begin
        if (!w_gcyc) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wd_cnt_nxt = '0;
    if ((TIMEOUT != 0) && w_busy && w_gcyc && s_stb_o &&
        !s_ack_i && !s_err_i)
      w_wd_cnt_nxt = r_wd_cnt + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_last   <= LW'(NUM_MASTERS - 1);
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_last   <= w_last_nxt;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a simple registered-ack RAM model.
module tb_wb_ram_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat = '0;
  logic [N*DW/8-1:0] m_sel = '0;
  logic [N-1:0]      m_we  = '0;
  logic [N-1:0]      m_cyc = '0;
  logic [N-1:0]      m_stb = '0;
  logic [N*3-1:0]    m_cti = '0;
  logic [N*2-1:0]    m_bte = '0;

  logic [DW-1:0]   m_rdat;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat;
  logic [DW/8-1:0] s_sel;
  logic            s_we;
  logic            s_cyc;
  logic            s_stb;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_rdat;
  logic            s_ack;
  logic            s_err;
  logic [N-1:0]    grant;
  logic            ram_en = 1'b1;

  int errors = 0;
  int checks = 0;

  assign s_err = 1'b0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .NUM_MASTERS(N),
    .AW(AW),
    .DW(DW),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .m_adr_i(m_adr),
    .m_dat_i(m_dat),
    .m_sel_i(m_sel),
    .m_we_i(m_we),
    .m_cyc_i(m_cyc),
    .m_stb_i(m_stb),
    .m_cti_i(m_cti),
    .m_bte_i(m_bte),
    .m_dat_o(m_rdat),
    .m_ack_o(m_ack),
    .m_err_o(m_err),
    .s_adr_o(s_adr),
    .s_dat_o(s_wdat),
    .s_sel_o(s_sel),
    .s_we_o(s_we),
    .s_cyc_o(s_cyc),
    .s_stb_o(s_stb),
    .s_cti_o(s_cti),
    .s_bte_o(s_bte),
    .s_dat_i(s_rdat),
    .s_ack_i(s_ack),
    .s_err_i(s_err),
    .grant_o(grant)
  );

  // RAM: one ack per strobe, data is a fixed function of the address.
  always @(posedge clk) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_rdat <= '0;
    end else begin
      s_ack  <= ram_en & s_cyc & s_stb & ~s_ack;
      s_rdat <= 32'hA5A50000 ^ s_adr;
    end
  end

  function automatic logic [N-1:0] oh(input int k);
    return N'(1) << k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input logic [31:0] a,
                     input logic [2:0] cti);
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    m_adr[k*AW +: AW] = a;
    m_cti[k*3 +: 3] = cti;
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rd(input int k, input logic [31:0] a);
    req(k, a, 3'b000);
    settle();
    chk("rd_idle", grant, '0);
    chk("rd_idle_cyc", s_cyc, 1'b0);
    step(); settle();
    chk("rd_grant", grant, oh(k));
    chk("rd_scyc", s_cyc, 1'b1);
    chk("rd_sadr", s_adr, a);
    step(); settle();
    chk("rd_ack", m_ack, oh(k));
    chk("rd_dat", m_rdat, 32'hA5A50000 ^ a);
    step();
    drop(k);
    settle();
    chk("rd_rel", s_cyc, 1'b0);
    step(); settle();
    chk("rd_idle2", grant, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    #90;
    chk("rst_grant", grant, '0);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_sstb", s_stb, 1'b0);
    chk("rst_ack", m_ack, '0);
    chk("rst_err", m_err, '0);
    #10;
    rst = 1'b0;
    step();

    // dbus single read
    rd(1, 32'h100);

    // ibus and dbus together
    do_reset();
    req(0, 32'h200, 3'b000);
    req(1, 32'h300, 3'b000);
    settle();
    chk("t2_idle", grant, '0);
    step(); settle();
    chk("t2_g0", grant, 3'b001);
    chk("t2_adr0", s_adr, 32'h200);
    step(); settle();
    chk("t2_ack0", m_ack, 3'b001);
    step();
    drop(0);
    settle();
    chk("t2_rel", s_cyc, 1'b0);
    chk("t2_hold", grant, 3'b001);
    step(); settle();
    chk("t2_gap", grant, '0);
    step(); settle();
    chk("t2_g1", grant, 3'b010);
    chk("t2_adr1", s_adr, 32'h300);
    step(); settle();
    chk("t2_ack1", m_ack, 3'b010);
    chk("t2_dat1", m_rdat, 32'hA5A50300);
    step();
    drop(1);
    step();

    // three continuous requesters
    do_reset();
    req(0, 32'h1000, 3'b000);
    req(1, 32'h1100, 3'b000);
    req(2, 32'h1200, 3'b000);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t3_idle", grant, '0);
      step(); settle();
      chk("t3_order", grant, oh(i % 3));
      step(); settle();
      chk("t3_ack", m_ack, oh(i % 3));
      step();
      drop(i % 3);
      step();
      if (i < 3)
        req(i % 3, 32'h1000 + 32'(i % 3) * 32'h100, 3'b000);
    end

    // ibus burst while debug waits
    req(0, 32'h400, 3'b010);
    req(2, 32'h500, 3'b000);
    settle();
    chk("t4_idle", grant, '0);
    step();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) m_adr[0 +: AW] = 32'h400 + 32'(4 * b);
      if (b == 3) m_cti[0 +: 3] = 3'b111;
      settle();
      chk("t4_wait", m_ack, '0);
      chk("t4_hold", grant, 3'b001);
      chk("t4_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
      step(); settle();
      chk("t4_beat", m_ack, 3'b001);
      chk("t4_dat", m_rdat, 32'hA5A50000 ^ (32'h400 + 32'(4 * b)));
      step();
    end
    drop(0);
    settle();
    chk("t4_rel_hold", grant, 3'b001);
    chk("t4_rel_cyc", s_cyc, 1'b0);
    step(); settle();
    chk("t4_gap", grant, '0);
    step(); settle();
    chk("t4_dbg", grant, 3'b100);
    chk("t4_dbg_adr", s_adr, 32'h500);
    step(); settle();
    chk("t4_dbg_ack", m_ack, 3'b100);
    step();
    drop(2);
    step();

    // watchdog with a silent RAM
    ram_en = 1'b0;
    req(2, 32'h600, 3'b000);
    settle();
    step();
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk("t5_stb", s_stb, 1'b1);
      chk("t5_noerr", m_err, '0);
      step();
    end
    settle();
    chk("t5_err", m_err, 3'b100);
    chk("t5_stbz", s_stb, 1'b0);
    chk("t5_noack", m_ack, '0);
    step();
    drop(2);
    settle();
    chk("t5_pulse", m_err, '0);
    step();
    ram_en = 1'b1;

    // reset mid-transfer restores master 0 priority
    rd(0, 32'h700);
    req(1, 32'h710, 3'b000);
    settle();
    step(); settle();
    chk("t6_grant", grant, 3'b010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t6_scyc", s_cyc, 1'b0);
    chk("t6_gz", grant, '0);
    chk("t6_noack", m_ack, '0);
    req(0, 32'h720, 3'b000);
    settle();
    step(); settle();
    chk("t6_prio", grant, 3'b001);
    step();
    drop(0);
    drop(1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
